// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared geometry and arbitration constants for the SRAM port controller.
package sram_ctrl_pkg;
  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 210;
  localparam int MASK_W       = 10;
  localparam int SEG_W        = DATA_W / MASK_W;
  localparam int RESP_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;
endpackage

// File: rtl/sram_resp_queue.sv
// sram_resp_queue: small FIFO holding read responses, with occupancy output.
module sram_resp_queue #(
  parameter  int DEPTH = 2,
  parameter  int W     = 8,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enq,
  input  logic [W-1:0]  enq_data,
  input  logic          deq,
  output logic [W-1:0]  deq_data,
  output logic [OW-1:0] occ,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (deq) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      occ <= occ + OW'(enq) - OW'(deq);
    end
  end
  always_ff @(posedge clock)
    if (enq) mem[wr_ptr] <= enq_data;
  assign deq_data = mem[rd_ptr];
  assign empty    = (occ == '0);
endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: arbitrates read/write requests onto one SRAM port and returns in-order read responses.
module sram_port_ctrl #(
  parameter int ADDR_W     = sram_ctrl_pkg::ADDR_W,
  parameter int DATA_W     = sram_ctrl_pkg::DATA_W,
  parameter int MASK_W     = sram_ctrl_pkg::MASK_W,
  parameter int RESP_DEPTH = sram_ctrl_pkg::RESP_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rreq_valid,
  output logic              rreq_ready,
  input  logic [ADDR_W-1:0] rreq_addr,
  input  logic              wreq_valid,
  output logic              wreq_ready,
  input  logic [ADDR_W-1:0] wreq_addr,
  input  logic [MASK_W-1:0] wreq_mask,
  input  logic [DATA_W-1:0] wreq_data,
  output logic              rresp_valid,
  input  logic              rresp_ready,
  output logic [DATA_W-1:0] rresp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  import sram_ctrl_pkg::*;
  localparam int OCC_W = $clog2(RESP_DEPTH + 1);
  logic [2:0]        starve;
  logic              inflight, empty, rd_ok, rd_gnt, wr_gnt, enq, deq;
  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] head;
  // Grants are gated by reset_n so the SRAM and handshakes go idle the instant reset asserts.
  always_comb begin
    rd_ok  = reset_n && rreq_valid && ((int'(occ) + int'(inflight)) < RESP_DEPTH);
    rd_gnt = rd_ok && (!wreq_valid || starve >= 3'(STARVE_LIMIT));
    wr_gnt = reset_n && wreq_valid && !rd_gnt;
    enq    = inflight && !(empty && rresp_ready);
    deq    = rresp_ready && !empty;
  end
  assign rreq_ready  = rd_gnt;
  assign wreq_ready  = wr_gnt;
  assign sram_en     = rd_gnt || wr_gnt;
  assign sram_wmode  = wr_gnt;
  assign sram_addr   = wr_gnt ? wreq_addr : rreq_addr;
  assign sram_wmask  = wr_gnt ? wreq_mask : '0;
  assign sram_wdata  = wr_gnt ? wreq_data : '0;
  assign rresp_valid = inflight || !empty;
  assign rresp_data  = empty ? sram_rdata : head;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_gnt;
      starve   <= (!rreq_valid || rd_gnt) ? '0 : (wr_gnt && starve != 3'd7) ? starve + 3'd1 : starve;
    end
  end
  sram_resp_queue #(.DEPTH(RESP_DEPTH), .W(DATA_W)) u_queue (
    .clock    (clock),
    .reset_n  (reset_n),
    .enq      (enq),
    .enq_data (sram_rdata),
    .deq      (deq),
    .deq_data (head),
    .occ      (occ),
    .empty    (empty)
  );
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: directed checks of arbitration, masking, response ordering and reset.
module tb_sram_port_ctrl;
  import sram_ctrl_pkg::*;
  logic              clock = 1'b0;
  logic              reset_n;
  logic              rreq_valid, rreq_ready, wreq_valid, wreq_ready;
  logic [ADDR_W-1:0] rreq_addr, wreq_addr, sram_addr;
  logic [MASK_W-1:0] wreq_mask, sram_wmask;
  logic [DATA_W-1:0] wreq_data, rresp_data, sram_wdata, sram_rdata;
  logic              rresp_valid, rresp_ready, sram_en, sram_wmode;
  logic [DATA_W-1:0] mem [512];
  logic [DATA_W-1:0] ones, a7_first, a7_second;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  sram_port_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
    .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr),
    .wreq_mask(wreq_mask), .wreq_data(wreq_data),
    .rresp_valid(rresp_valid), .rresp_ready(rresp_ready), .rresp_data(rresp_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM: masked write, read data valid the cycle after enable.
  always @(posedge clock)
    if (sram_en) begin
      if (sram_wmode) begin
        for (int s = 0; s < MASK_W; s++)
          if (sram_wmask[s]) mem[sram_addr][s*SEG_W +: SEG_W] <= sram_wdata[s*SEG_W +: SEG_W];
      end else sram_rdata <= mem[sram_addr];
    end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    ones      = '1;
    a7_first  = DATA_W'(21'h1FFFFF);
    a7_second = DATA_W'(42'h3FF_FFFF_FFFF);
    sram_rdata = '0;
    reset_n = 1'b0; rreq_valid = 1'b1; wreq_valid = 1'b1; rresp_ready = 1'b0;
    rreq_addr = '0; wreq_addr = '0; wreq_mask = '0; wreq_data = '0;
    step(); #1;
    chk("rst_sram_en", sram_en, 0);
    chk("rst_wmode", sram_wmode, 0);
    chk("rst_rreq_ready", rreq_ready, 0);
    chk("rst_wreq_ready", wreq_ready, 0);
    chk("rst_rresp_valid", rresp_valid, 0);
    rreq_valid = 1'b0; wreq_valid = 1'b0;
    step(); reset_n = 1'b1;
    // Write-then-read of the same address
    step(); wreq_valid = 1'b1; wreq_addr = 9'd5; wreq_mask = 10'h3FF; wreq_data = ones; #1;
    chk("w5_ready", wreq_ready, 1);
    chk("w5_wmode", sram_wmode, 1);
    chk("w5_en", sram_en, 1);
    chk("w5_addr", sram_addr, 5);
    chk("w5_wmask", sram_wmask, 10'h3FF);
    step(); wreq_valid = 1'b0; rreq_valid = 1'b1; rreq_addr = 9'd5; rresp_ready = 1'b1; #1;
    chk("r5_ready", rreq_ready, 1);
    chk("r5_wmode", sram_wmode, 0);
    chk("r5_wmask", sram_wmask, 0);
    chk("r5_en", sram_en, 1);
    chk("r5_no_early_valid", rresp_valid, 0);
    step(); rreq_valid = 1'b0; #1;
    chk("r5_resp_valid", rresp_valid, 1);
    chk("r5_resp_data", rresp_data, ones);
    step(); #1;
    chk("r5_resp_done", rresp_valid, 0);
    // Single-segment masked write over zeros
    step(); wreq_valid = 1'b1; wreq_addr = 9'd7; wreq_mask = 10'h001; wreq_data = a7_first; #1;
    chk("w7_ready", wreq_ready, 1);
    step(); wreq_valid = 1'b0; rreq_valid = 1'b1; rreq_addr = 9'd7;
    step(); rreq_valid = 1'b0; #1;
    chk("r7_valid", rresp_valid, 1);
    chk("r7_data", rresp_data, a7_first);
    step(); wreq_valid = 1'b1; wreq_addr = 9'd7; wreq_mask = 10'h002; wreq_data = ones;
    step(); wreq_valid = 1'b0;
    // Starvation: 4 writes then 1 read, repeating
    step(); wreq_valid = 1'b1; wreq_addr = 9'd10; wreq_mask = 10'h3FF; wreq_data = '0;
    rreq_valid = 1'b1; rreq_addr = 9'd5;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("arb_w%0d", i), wreq_ready, (i % 5) != 4);
      chk($sformatf("arb_r%0d", i), rreq_ready, (i % 5) == 4);
      if (i == 5) chk("arb_resp", rresp_data, ones);
      step();
    end
    wreq_valid = 1'b0; rreq_valid = 1'b0;
    step();
    // Backpressure: queue capacity limits outstanding reads
    rresp_ready = 1'b0; rreq_valid = 1'b1; rreq_addr = 9'd5; #1;
    chk("bp_r0_ready", rreq_ready, 1);
    step(); rreq_addr = 9'd7; #1;
    chk("bp_r1_ready", rreq_ready, 1);
    chk("bp_ft_valid", rresp_valid, 1);
    chk("bp_ft_data", rresp_data, ones);
    step(); rreq_addr = 9'd10; #1;
    chk("bp_full0", rreq_ready, 0);
    chk("bp_hold", rresp_data, ones);
    step(); #1;
    chk("bp_full1", rreq_ready, 0);
    chk("bp_hold_valid", rresp_valid, 1);
    step(); rreq_valid = 1'b0; rresp_ready = 1'b1; #1;
    chk("bp_q0_data", rresp_data, ones);
    step(); rreq_valid = 1'b1; rreq_addr = 9'd5; #1;
    chk("bp_reassert", rreq_ready, 1);
    chk("bp_q1_data", rresp_data, a7_second);
    step(); rreq_valid = 1'b0; #1;
    chk("bp_ft2_valid", rresp_valid, 1);
    chk("bp_ft2_data", rresp_data, ones);
    step(); #1;
    chk("bp_drained", rresp_valid, 0);
    // Reset while a read is in flight
    step(); rreq_valid = 1'b1; rreq_addr = 9'd7; #1;
    chk("rr_grant", rreq_ready, 1);
    step(); reset_n = 1'b0; #1;
    chk("rr_en", sram_en, 0);
    chk("rr_ready", rreq_ready, 0);
    chk("rr_valid", rresp_valid, 0);
    step(); rreq_valid = 1'b0; reset_n = 1'b1; #1;
    chk("rr_post0", rresp_valid, 0);
    step(); #1;
    chk("rr_post1", rresp_valid, 0);
    rreq_valid = 1'b1; rreq_addr = 9'd7; #1;
    chk("rr_again", rreq_ready, 1);
    step(); rreq_valid = 1'b0; #1;
    chk("rr_ft_valid", rresp_valid, 1);
    chk("rr_ft_data", rresp_data, a7_second);
    step(); #1;
    chk("rr_idle", rresp_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
